// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM channel controller: register offsets,
// CTRL/STATUS bit positions and the sequencer state encoding.
package pwm_pkg;

    localparam int CTRL_A   = 0;
    localparam int PERIOD_A = 1;
    localparam int DUTY_A   = 2;
    localparam int STATUS_A = 3;
    localparam int COUNT_A  = 4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_POL     = 3;

    localparam int STAT_PEND    = 0;
    localparam int STAT_RUNNING = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_ctrl_if.sv
// Peripheral-bus register access port of the PWM controller.
interface pwm_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              we;
    logic              re;
    logic [WIDTH-1:0]  rdata;

    modport master (output addr, output wdata, output we, output re, input rdata);
    modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/pwm_shadow_reg.sv
// Active (shadow) copy of a staging register; reloads on strobe, holds otherwise.
module pwm_shadow_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pwm_ctrl.sv
// PWM channel controller: register file, period sequencer and duty compare.
//   state | meaning
//   IDLE  | stopped, count held at 0, output at idle (polarity) level
//   LOAD  | one cycle: staging copied into active period/duty
//   RUN   | counting 0..period_act, waveform driven from duty compare
module pwm_ctrl
    import pwm_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    pwm_ctrl_if.slave  bus,
    output logic       pwm_out,
    output logic       rollover,
    output logic       irq
);

    pwm_state_e        state;
    logic [3:0]        ctrl_q;
    logic [WIDTH-1:0]  period_stg;
    logic [WIDTH-1:0]  duty_stg;
    logic [WIDTH-1:0]  period_act;
    logic [WIDTH-1:0]  duty_act;
    logic [WIDTH-1:0]  count;
    logic              irq_pend;

    logic [ADDR_W-1:0] sel;
    logic              enable;
    logic              oneshot;
    logic              irq_en;
    logic              polarity;
    logic              wr_ctrl;
    logic              wr_period;
    logic              wr_duty;
    logic              wr_status;
    logic              at_end;
    logic              os_stop;
    logic              shadow_load;
    logic [1:0]        status_v;
    logic [WIDTH-1:0]  rd_val;

    assign sel      = bus.addr;
    assign enable   = ctrl_q[CTRL_EN];
    assign oneshot  = ctrl_q[CTRL_ONESHOT];
    assign irq_en   = ctrl_q[CTRL_IRQ_EN];
    assign polarity = ctrl_q[CTRL_POL];

    // Rollover is a decode of registered state, so it lines up with the last count.
    assign at_end      = (count == period_act);
    assign rollover    = (state == RUN) && enable && at_end;
    assign os_stop     = rollover && oneshot;
    assign shadow_load = (state == LOAD) || (rollover && !oneshot);
    assign irq         = irq_pend & irq_en;

    assign status_v = {(state == RUN), irq_pend};

    always_comb begin
        wr_ctrl   = 1'b0;
        wr_period = 1'b0;
        wr_duty   = 1'b0;
        wr_status = 1'b0;
        if (bus.we) begin
            case (int'(sel))
                CTRL_A:   wr_ctrl   = 1'b1;
                PERIOD_A: wr_period = 1'b1;
                DUTY_A:   wr_duty   = 1'b1;
                STATUS_A: wr_status = 1'b1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (int'(sel))
            CTRL_A:   rd_val = WIDTH'(ctrl_q);
            PERIOD_A: rd_val = period_stg;
            DUTY_A:   rd_val = duty_stg;
            STATUS_A: rd_val = WIDTH'(status_v);
            COUNT_A:  rd_val = count;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q     <= '0;
            period_stg <= '0;
            duty_stg   <= '0;
            irq_pend   <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            // A one-shot completion drops enable so IDLE does not re-arm.
            if (wr_ctrl) begin
                ctrl_q <= bus.wdata[3:0];
            end else if (os_stop) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end
            if (wr_period) period_stg <= bus.wdata;
            if (wr_duty)   duty_stg   <= bus.wdata;
            if (rollover) begin
                irq_pend <= 1'b1;
            end else if (wr_status && bus.wdata[STAT_PEND]) begin
                irq_pend <= 1'b0;
            end
            if (bus.re) bus.rdata <= rd_val;
        end
    end

    pwm_shadow_reg #(.WIDTH(WIDTH)) u_period_act (
        .clk  (clk),
        .rst  (rst),
        .load (shadow_load),
        .d    (period_stg),
        .q    (period_act)
    );

    pwm_shadow_reg #(.WIDTH(WIDTH)) u_duty_act (
        .clk  (clk),
        .rst  (rst),
        .load (shadow_load),
        .d    (duty_stg),
        .q    (duty_act)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            pwm_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count   <= '0;
                    pwm_out <= polarity;
                    if (enable) state <= LOAD;
                end
                LOAD: begin
                    count   <= '0;
                    pwm_out <= polarity;
                    state   <= enable ? RUN : IDLE;
                end
                RUN: begin
                    if (!enable) begin
                        state   <= IDLE;
                        count   <= '0;
                        pwm_out <= polarity;
                    end else begin
                        pwm_out <= (count < duty_act) ^ polarity;
                        if (at_end) begin
                            count <= '0;
                            if (oneshot) state <= IDLE;
                        end else begin
                            count <= count + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    count   <= '0;
                    pwm_out <= polarity;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ctrl.sv
// Bench for pwm_ctrl: directed scenarios plus randomized register traffic,
// every cycle compared against a behavioural model of the channel.
module tb_pwm_ctrl;
    localparam int W  = 16;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    logic pwm_out;
    logic rollover;
    logic irq;

    pwm_ctrl_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

    pwm_ctrl #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pwm_out  (pwm_out),
        .rollover (rollover),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: mode 0 stopped, 1 arming, 2 counting
    int         m_mode;
    logic [3:0] m_ctrl;
    logic [W-1:0] m_per_stg, m_duty_stg, m_per, m_duty, m_cnt, m_rdata;
    logic       m_pend;
    logic       m_pwm;

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_roll();
        return (m_mode == 2) && m_ctrl[0] && (m_cnt == m_per);
    endfunction

    function automatic logic [W-1:0] model_read(int a);
        case (a)
            0:       return W'(m_ctrl);
            1:       return m_per_stg;
            2:       return m_duty_stg;
            3:       return W'({(m_mode == 2), m_pend});
            4:       return m_cnt;
            default: return '0;
        endcase
    endfunction

    task automatic model_edge();
        logic roll;
        logic os;
        int   a;
        a = int'(bus.addr);
        if (!rst) begin
            m_mode = 0; m_ctrl = '0; m_per_stg = '0; m_duty_stg = '0;
            m_per = '0; m_duty = '0; m_cnt = '0; m_rdata = '0;
            m_pend = 1'b0; m_pwm = 1'b0;
            return;
        end
        roll = model_roll();
        os   = roll && m_ctrl[1];
        if (bus.re) m_rdata = model_read(a);
        case (m_mode)
            0: begin
                m_cnt = '0; m_pwm = m_ctrl[3];
                if (m_ctrl[0]) m_mode = 1;
            end
            1: begin
                m_cnt = '0; m_pwm = m_ctrl[3];
                m_per = m_per_stg; m_duty = m_duty_stg;
                m_mode = m_ctrl[0] ? 2 : 0;
            end
            default: begin
                if (!m_ctrl[0]) begin
                    m_mode = 0; m_cnt = '0; m_pwm = m_ctrl[3];
                end else begin
                    m_pwm = (m_cnt < m_duty) ^ m_ctrl[3];
                    if (roll) begin
                        m_cnt = '0;
                        if (m_ctrl[1]) m_mode = 0;
                        else begin m_per = m_per_stg; m_duty = m_duty_stg; end
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end
        endcase
        if (bus.we && a == 0) m_ctrl = bus.wdata[3:0];
        else if (os) m_ctrl[0] = 1'b0;
        if (bus.we && a == 1) m_per_stg = bus.wdata;
        if (bus.we && a == 2) m_duty_stg = bus.wdata;
        if (roll) m_pend = 1'b1;
        else if (bus.we && a == 3 && bus.wdata[0]) m_pend = 1'b0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("pwm_out", W'(pwm_out), W'(m_pwm));
        check("rollover", W'(rollover), W'(model_roll()));
        check("irq", W'(irq), W'(m_pend & m_ctrl[2]));
        check("rdata", bus.rdata, m_rdata);
        bus.we = 1'b0;
        bus.re = 1'b0;
    endtask

    task automatic wr(int a, int d);
        bus.addr = AW'(a); bus.wdata = W'(d); bus.we = 1'b1;
        tick();
    endtask

    task automatic rd(int a);
        bus.addr = AW'(a); bus.re = 1'b1;
        tick();
    endtask

    logic [9:0] pw_bits, ro_bits;
    int         n_roll;

    initial begin
        rst = 1'b0; bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
        tick(); tick();
        rst = 1'b1;
        check("reset_pwm", W'(pwm_out), 0);
        check("reset_rdata", bus.rdata, 0);

        // PERIOD=4 DUTY=2: 1,1,0,0,0 with rollover at count 4
        wr(1, 4); wr(2, 2); wr(0, 1);
        tick(); tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            pw_bits[k] = pwm_out;
            ro_bits[k] = rollover;
        end
        check("pattern_pwm", W'(pw_bits), W'(10'b0001100011));
        check("pattern_roll", W'(ro_bits), W'(10'b0100001000));

        // DUTY=4 written at count 1: current period keeps 2-high
        tick();
        wr(2, 4);
        for (int k = 0; k < 10; k++) begin
            tick();
            pw_bits[k] = pwm_out;
        end
        check("duty_change", W'(pw_bits), W'(10'b1101111000));

        // Edge duties
        wr(0, 0); wr(2, 0); wr(1, 4); wr(0, 1);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("duty0_const", W'(pwm_out), 0);
        end
        wr(0, 0); wr(2, 9); wr(0, 1); tick(); tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("duty_gt_period", W'(pwm_out), 1);
        end
        wr(0, 0); wr(1, 0); wr(2, 1); wr(0, 1); tick(); tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            check("period0_roll", W'(rollover), 1);
            check("period0_pwm", W'(pwm_out), 1);
        end

        // One-shot with interrupt
        wr(0, 0); wr(3, 1);
        check("irq_cleared", W'(irq), 0);
        wr(1, 3); wr(0, 7);
        n_roll = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (rollover) n_roll++;
        end
        check("oneshot_rolls", W'(n_roll), 1);
        rd(3);
        check("oneshot_status", bus.rdata, 1);
        check("oneshot_irq", W'(irq), 1);
        wr(3, 1);
        check("w1c_irq", W'(irq), 0);

        // Polarity 1, DUTY=1, PERIOD=2: 0,1,1
        wr(0, 0); wr(1, 2); wr(2, 1); wr(0, 9); tick(); tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            pw_bits[k] = pwm_out;
        end
        check("polarity_pat", W'(pw_bits[5:0]), W'(6'b110110));
        tick();
        wr(0, 8);
        tick();
        check("disable_pwm", W'(pwm_out), 1);
        check("disable_roll", W'(rollover), 0);
        rd(4);
        check("disable_count", bus.rdata, 0);

        // Randomized register traffic
        for (int it = 0; it < 20; it++) begin
            wr(0, 0);
            wr(1, int'($urandom_range(0, 7)));
            wr(2, int'($urandom_range(0, 9)));
            wr(0, int'({$urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 1'b1}) & 4'hD);
            for (int c = 0; c < 30; c++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 30) begin
                    bus.addr = AW'($urandom_range(0, 7)); bus.re = 1'b1;
                end
                if (r >= 30 && r < 45) begin
                    bus.addr = AW'(2); bus.wdata = W'($urandom_range(0, 9)); bus.we = 1'b1;
                end else if (r >= 45 && r < 52) begin
                    bus.addr = AW'(1); bus.wdata = W'($urandom_range(0, 7)); bus.we = 1'b1;
                end else if (r >= 52 && r < 56) begin
                    bus.addr = AW'(3); bus.wdata = W'(1); bus.we = 1'b1;
                end else if (r >= 56 && r < 59) begin
                    bus.addr = AW'(0); bus.wdata = W'($urandom_range(0, 15)); bus.we = 1'b1;
                end
                tick();
            end
        end

        // Reset mid-run overrides a concurrent write/read
        wr(1, 5); wr(2, 3); wr(0, 5); tick(); tick(); tick();
        rst = 1'b0; bus.addr = AW'(1); bus.wdata = W'(7); bus.we = 1'b1; bus.re = 1'b1;
        tick();
        rst = 1'b1;
        check("rst_pwm", W'(pwm_out), 0);
        check("rst_roll", W'(rollover), 0);
        check("rst_irq", W'(irq), 0);
        for (int a = 0; a < 8; a++) begin
            rd(a);
            check("rst_regs", bus.rdata, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_ctrl.md
Name: pwm_ctrl

Overview:
Memory-mapped PWM channel controller for the simpleRisc SOC peripheral bus. It holds the CPU-writable period and duty staging registers and sequences the period counter. It transfers staged values into active (shadow) registers only at period boundaries, so the duty/period seen by the waveform never changes mid-period. It also generates rollover, one-shot stop and interrupt events.

Parameters:
WIDTH, 16, counter / period / duty width in bits
ADDR_W, 3, register-select address width (word offsets)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset; sampled on posedge clk
addr  in  ADDR_W  register select
wdata  in  WIDTH  write data
we  in  1  write strobe, one-cycle
re  in  1  read strobe, one-cycle
rdata  out  WIDTH  read data, registered
pwm_out  out  1  PWM waveform, registered
rollover  out  1  one-cycle pulse at the last count of each period
irq  out  1  level interrupt = irq_pend & irq_en

Behaviour:
- Register map (addr):
  - 0 CTRL rw: [0] enable, [1] oneshot, [2] irq_en, [3] polarity.
  - 1 PERIOD rw: staging.
  - 2 DUTY rw: staging.
  - 3 STATUS: [0] irq_pend, write-1-to-clear; [1] running, read-only.
  - 4 COUNT ro.
  - Other addresses: reads return 0, writes are ignored.
- Reset (rst=0 at posedge): CTRL, PERIOD, DUTY, active regs, count, rdata = 0; pwm_out=0; rollover=0; irq_pend=0; state=IDLE. Reset overrides any concurrent we/re.
- rdata: updated the cycle after re. Holds its value when re=0.
- FSM IDLE / LOAD / RUN:
  - IDLE: count=0; pwm_out=polarity; running=0. When enable=1 -> LOAD.
  - LOAD (one cycle): period_act<=PERIOD, duty_act<=DUTY, count<=0 -> RUN.
  - RUN: running=1; count increments by 1 each cycle.
    - When count==period_act: rollover=1 that cycle, irq_pend<=1, count<=0, period_act/duty_act reload from staging on the same edge.
    - If oneshot=1 at that edge: -> IDLE instead, with no reload.
  - enable cleared while in RUN or LOAD: -> IDLE next edge; count=0; no rollover.
- Waveform: pwm_out(t+1) = (count(t) < duty_act) XOR polarity while in RUN.
  - Period length = period_act+1 cycles.
  - duty_act=0 gives constant inactive level.
  - duty_act > period_act gives constant active level (100%), no wrap.
  - period_act=0 gives rollover every cycle.
- Staging writes during RUN take effect only at the next rollover. A write in the same cycle as rollover is not captured; the old staging value loads and the new value applies from the following period.
- irq_pend set and W1C in the same cycle: set wins.
- Arithmetic: unsigned WIDTH-bit. The counter never exceeds period_act, so there is no overflow wrap.

Decomposition:
- Shared package pwm_pkg:
  - Register offset constants (CTRL_A, PERIOD_A, DUTY_A, STATUS_A, COUNT_A).
  - CTRL bit-index constants.
  - FSM state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2).
- One sub-module, pwm_shadow_reg: a WIDTH-wide register with a reload-on-strobe, hold-otherwise behaviour. Instantiate it twice (period_act, duty_act).
- Bus decode, FSM, counter and compare stay in pwm_ctrl.

Test Plan:
- Reset mid-RUN: rst=0 for 1 cycle -> state IDLE, count=0, pwm_out=0, rollover=0, irq=0, and all registers read 0 afterwards.
- PERIOD=4, DUTY=2, CTRL=1 -> after LOAD, repeating pwm_out pattern 1,1,0,0,0; rollover pulses every 5 cycles at COUNT=4.
- While running with PERIOD=4, DUTY=2, write DUTY=4 at COUNT=1 -> current period stays 2-high; next period 4-high, 1-low.
- Edge duties: DUTY=0 -> pwm_out constant 0. DUTY=9 with PERIOD=4 -> constant 1. PERIOD=0, DUTY=1 -> rollover asserted every cycle, pwm_out=1.
- CTRL=0x7 (enable, oneshot, irq_en), PERIOD=3 -> exactly one rollover, FSM returns to IDLE, STATUS=0x1, irq=1. Write STATUS=1 -> irq=0 next cycle.
- Polarity=1, DUTY=1, PERIOD=2 -> pattern 0,1,1. Clearing enable mid-period -> pwm_out=1 (idle level) and COUNT=0 the next cycle, with no rollover.
